// File: rtl/wifi_tx_pkg.sv
// Shared constants and read-FSM state type for the WiFi transmit cyclic-prefix path.
package wifi_tx_pkg;

    localparam int unsigned N_FFT    = 64;
    localparam int unsigned CP_LEN   = 16;
    localparam int unsigned CP_START = N_FFT - CP_LEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        BODY = 2'd2
    } cp_state_t;

endpackage

// File: rtl/cp_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read port; bank select is the address MSB.
module cp_dpram #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/wifi_cp_inserter.sv
// Cyclic-prefix inserter: ping-pong buffers 64-point IFFT symbols and streams CP(16) + body(64).
// Optional build macro WIFI_CP_WINDOW_EN: CP sample 0 becomes (x[48] + previous x[0]) >>> 1.
module wifi_cp_inserter
    import wifi_tx_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 12,
    parameter int unsigned INDEX_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] data_in_real,
    input  logic [SAMPLE_WIDTH-1:0] data_in_imag,
    input  logic [INDEX_WIDTH-1:0]  index_in,
    input  logic                    valid_in,
    input  logic                    last_symbol_in,
    output logic                    ready_out,
    output logic [SAMPLE_WIDTH-1:0] data_out_real,
    output logic [SAMPLE_WIDTH-1:0] data_out_imag,
    output logic                    valid_out,
    output logic                    symbol_start,
    output logic                    burst_end,
    output logic                    overflow
);

    localparam int unsigned ADDR_W = INDEX_WIDTH + 1;
    localparam int unsigned DATA_W = 2 * SAMPLE_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(N_FFT - 1);
    localparam logic [INDEX_WIDTH-1:0] CP_FIRST = INDEX_WIDTH'(CP_START);

    logic                    w_accept;
    logic                    w_done;
    logic                    w_wr_bank_nxt;
    logic [1:0]              w_full_nxt;
    logic [1:0]              r_full;
    logic [1:0]              r_last;
    logic                    r_wr_bank;
    logic                    r_wr_en;
    logic                    r_wr_done;
    logic                    r_wr_lsym;
    logic                    r_wr_tgt;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic [DATA_W-1:0]       r_wr_data;

    cp_state_t               r_state;
    cp_state_t               w_state_nxt;
    logic                    r_rd_bank;
    logic                    w_rd_bank_nxt;
    logic [INDEX_WIDTH-1:0]  r_rd_addr;
    logic [INDEX_WIDTH-1:0]  w_rd_addr_nxt;
    logic                    w_rd_en;
    logic                    w_rd_sop;
    logic                    w_rd_eob;
    logic                    w_free;
    logic                    r_rd_vld;
    logic                    r_rd_sop;
    logic                    r_rd_eob;

    logic [DATA_W-1:0]       w_ram_data;
    logic [SAMPLE_WIDTH-1:0] w_ram_re;
    logic [SAMPLE_WIDTH-1:0] w_ram_im;
    logic [SAMPLE_WIDTH-1:0] w_pre_re;
    logic [SAMPLE_WIDTH-1:0] w_pre_im;

    assign w_accept      = valid_in & ready_out;
    assign w_done        = w_accept & (index_in == LAST_IDX);
    assign w_wr_bank_nxt = r_wr_bank ^ w_done;

    // Reader frees its bank while a completed write marks the other; both apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_free) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (r_wr_done) begin
            w_full_nxt[r_wr_tgt] = 1'b1;
        end
    end

    // Input capture stage: the RAM write and full flag land one cycle after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_tgt  <= 1'b0;
            r_wr_lsym <= 1'b0;
            r_wr_done <= 1'b0;
            r_wr_bank <= 1'b0;
            r_full    <= '0;
            r_last    <= '0;
            ready_out <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= {r_wr_bank, index_in};
                r_wr_data <= {data_in_real, data_in_imag};
                r_wr_tgt  <= r_wr_bank;
                r_wr_lsym <= last_symbol_in;
            end
            r_wr_done <= w_done;
            r_wr_bank <= w_wr_bank_nxt;
            r_full    <= w_full_nxt;
            if (r_wr_done) begin
                r_last[r_wr_tgt] <= r_wr_lsym;
            end
            ready_out <= !w_full_nxt[w_wr_bank_nxt];
            if (valid_in && !ready_out) begin
                overflow <= 1'b1;
            end
        end
    end

    cp_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (r_wr_en),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (r_wr_data),
        .i_rd_addr ({w_rd_bank_nxt, w_rd_addr_nxt}),
        .o_rd_data (w_ram_data)
    );

    // Read sequencer: the next-address terms drive the RAM, so data lands with the state update.
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_addr_nxt = r_rd_addr;
        w_rd_bank_nxt = r_rd_bank;
        w_rd_en       = 1'b0;
        w_rd_sop      = 1'b0;
        w_rd_eob      = 1'b0;
        w_free        = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt   = CP;
                    w_rd_addr_nxt = CP_FIRST;
                    w_rd_en       = 1'b1;
                    w_rd_sop      = 1'b1;
                end
            end
            CP: begin
                w_rd_en       = 1'b1;
                w_rd_addr_nxt = INDEX_WIDTH'(r_rd_addr + 1'b1);
                if (r_rd_addr == LAST_IDX) begin
                    w_state_nxt = BODY;
                end
            end
            BODY: begin
                if (r_rd_addr == LAST_IDX) begin
                    w_free        = 1'b1;
                    w_rd_bank_nxt = ~r_rd_bank;
                    if (r_full[~r_rd_bank]) begin
                        w_state_nxt   = CP;
                        w_rd_addr_nxt = CP_FIRST;
                        w_rd_en       = 1'b1;
                        w_rd_sop      = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_rd_en       = 1'b1;
                    w_rd_addr_nxt = INDEX_WIDTH'(r_rd_addr + 1'b1);
                    w_rd_eob      = (w_rd_addr_nxt == LAST_IDX) && r_last[r_rd_bank];
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_sop  <= 1'b0;
            r_rd_eob  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_rd_vld  <= w_rd_en;
            r_rd_sop  <= w_rd_sop;
            r_rd_eob  <= w_rd_eob;
        end
    end

    assign w_ram_re = w_ram_data[DATA_W-1:SAMPLE_WIDTH];
    assign w_ram_im = w_ram_data[SAMPLE_WIDTH-1:0];

`ifdef WIFI_CP_WINDOW_EN
    logic                    r_rd_body0;
    logic [SAMPLE_WIDTH-1:0] r_prev_re;
    logic [SAMPLE_WIDTH-1:0] r_prev_im;
    logic [SAMPLE_WIDTH:0]   w_sum_re;
    logic [SAMPLE_WIDTH:0]   w_sum_im;

    // Previous symbol's x[0] is held for the boundary window; a burst end restarts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_body0 <= 1'b0;
            r_prev_re  <= '0;
            r_prev_im  <= '0;
        end else begin
            r_rd_body0 <= (r_state == CP) && (r_rd_addr == LAST_IDX);
            if (r_rd_eob) begin
                r_prev_re <= '0;
                r_prev_im <= '0;
            end else if (r_rd_body0) begin
                r_prev_re <= w_ram_re;
                r_prev_im <= w_ram_im;
            end
        end
    end

    assign w_sum_re = {w_ram_re[SAMPLE_WIDTH-1], w_ram_re} + {r_prev_re[SAMPLE_WIDTH-1], r_prev_re};
    assign w_sum_im = {w_ram_im[SAMPLE_WIDTH-1], w_ram_im} + {r_prev_im[SAMPLE_WIDTH-1], r_prev_im};
    assign w_pre_re = r_rd_sop ? w_sum_re[SAMPLE_WIDTH:1] : w_ram_re;
    assign w_pre_im = r_rd_sop ? w_sum_im[SAMPLE_WIDTH:1] : w_ram_im;
`else
    assign w_pre_re = w_ram_re;
    assign w_pre_im = w_ram_im;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out     <= 1'b0;
            data_out_real <= '0;
            data_out_imag <= '0;
            symbol_start  <= 1'b0;
            burst_end     <= 1'b0;
        end else begin
            valid_out     <= r_rd_vld;
            data_out_real <= r_rd_vld ? w_pre_re : '0;
            data_out_imag <= r_rd_vld ? w_pre_im : '0;
            symbol_start  <= r_rd_sop;
            burst_end     <= r_rd_eob;
        end
    end

endmodule

// File: tb/tb_wifi_cp_inserter.sv
// Directed bench for wifi_cp_inserter: framing table, sustained rate, overflow and mid-body reset.
module tb_wifi_cp_inserter;

    localparam int SW = 12;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] data_in_real;
    logic [SW-1:0] data_in_imag;
    logic [IW-1:0] index_in;
    logic          valid_in;
    logic          last_symbol_in;
    logic          ready_out;
    logic [SW-1:0] data_out_real;
    logic [SW-1:0] data_out_imag;
    logic          valid_out;
    logic          symbol_start;
    logic          burst_end;
    logic          overflow;

    wifi_cp_inserter #(.SAMPLE_WIDTH(SW), .INDEX_WIDTH(IW)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_real   (data_in_real),
        .data_in_imag   (data_in_imag),
        .index_in       (index_in),
        .valid_in       (valid_in),
        .last_symbol_in (last_symbol_in),
        .ready_out      (ready_out),
        .data_out_real  (data_out_real),
        .data_out_imag  (data_out_imag),
        .valid_out      (valid_out),
        .symbol_start   (symbol_start),
        .burst_end      (burst_end),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int base_re;
        int base_im;
        bit last;
        bit rev;
        int cp0;
        int cp0_win;
        int body0;
        int body63;
        bit burst;
    } vec_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  idle_bad = 0;
    int  q_re[$], q_im[$], q_cyc[$];
    bit  q_sop[$], q_eob[$];
    int  exp_re[$], exp_im[$];
    bit  exp_sop[$], exp_eob[$];
    int  sym_re[64], sym_im[64];
    int  drive_n, first_low, first_ovf;
`ifdef WIFI_CP_WINDOW_EN
    int  m_prev_re = 0;
    int  m_prev_im = 0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: log valid samples, and note any idle-cycle data or stray pulses.
    always @(negedge clk) begin
        if (valid_out) begin
            q_re.push_back(int'($signed(data_out_real)));
            q_im.push_back(int'($signed(data_out_imag)));
            q_sop.push_back(symbol_start);
            q_eob.push_back(burst_end);
            q_cyc.push_back(cyc);
        end else if (data_out_real != '0 || data_out_imag != '0 || symbol_start || burst_end) begin
            idle_bad++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    function automatic int wrap(input int v);
        logic signed [SW-1:0] t;
        t = SW'(v);
        return int'(t);
    endfunction

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_re.delete(); q_im.delete(); q_sop.delete(); q_eob.delete(); q_cyc.delete();
        exp_re.delete(); exp_im.delete(); exp_sop.delete(); exp_eob.delete();
    endtask

    task automatic pad_q(input int n);
        while (q_re.size() < n) begin
            q_re.push_back(-99999); q_im.push_back(-99999);
            q_sop.push_back(1'b0); q_eob.push_back(1'b0); q_cyc.push_back(-100000);
        end
    endtask

    task automatic fill_sym(input int base_re, input int base_im);
        for (int i = 0; i < 64; i++) begin
            sym_re[i] = wrap(base_re + i);
            sym_im[i] = wrap(base_im - i);
        end
    endtask

    // Reference framing: x[48..63] then x[0..63], with the optional boundary window on sample 0.
    task automatic model_push(input bit last);
        for (int k = 0; k < 80; k++) begin
            int i;
            int re;
            int im;
            i  = (k < 16) ? 48 + k : k - 16;
            re = sym_re[i];
            im = sym_im[i];
`ifdef WIFI_CP_WINDOW_EN
            if (k == 0) begin
                re = (sym_re[48] + m_prev_re) >>> 1;
                im = (sym_im[48] + m_prev_im) >>> 1;
            end
`endif
            exp_re.push_back(re);
            exp_im.push_back(im);
            exp_sop.push_back(k == 0);
            exp_eob.push_back((k == 79) && last);
        end
`ifdef WIFI_CP_WINDOW_EN
        m_prev_re = last ? 0 : sym_re[0];
        m_prev_im = last ? 0 : sym_im[0];
`endif
    endtask

    task automatic write_sym(input bit last, input bit rev);
        for (int k = 0; k < 64; k++) begin
            int idx;
            idx = rev ? ((k == 63) ? 63 : 62 - k) : k;
            data_in_real   = SW'(sym_re[idx]);
            data_in_imag   = SW'(sym_im[idx]);
            index_in       = IW'(idx);
            valid_in       = 1'b1;
            last_symbol_in = (idx == 63) ? last : 1'b0;
            if (!ready_out && first_low < 0) first_low = drive_n;
            if (overflow && first_ovf < 0) first_ovf = drive_n;
            drive_n++;
            step();
        end
        valid_in       = 1'b0;
        last_symbol_in = 1'b0;
    endtask

    task automatic wait_q(input int n, input int budget);
        int c;
        c = 0;
        while (q_re.size() < n && c < budget) begin
            step();
            c++;
        end
    endtask

    task automatic cmp_seq(input string name, input int n);
        int bad_d;
        int bad_f;
        bad_d = 0;
        bad_f = 0;
        for (int i = 0; i < n; i++) begin
            if (q_re[i] != exp_re[i] || q_im[i] != exp_im[i]) bad_d++;
            if (q_sop[i] != exp_sop[i] || q_eob[i] != exp_eob[i]) bad_f++;
        end
        check({name, "_data"}, bad_d, 0);
        check({name, "_flags"}, bad_f, 0);
    endtask

    function automatic int state_vec();
        return int'({ready_out, valid_out, symbol_start, burst_end, overflow,
                     data_out_real, data_out_imag});
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int expc;
        clear_q();
        fill_sym(v.base_re, v.base_im);
        model_push(v.last);
        write_sym(v.last, v.rev);
        lat = 0;
        while (!valid_out && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        wait_q(80, 200);
        repeat (5) step();
        check({tag, "_count"}, q_re.size(), 80);
        pad_q(80);
        check({tag, "_contig"}, q_cyc[79] - q_cyc[0], 79);
`ifdef WIFI_CP_WINDOW_EN
        expc = v.cp0_win;
`else
        expc = v.cp0;
`endif
        check({tag, "_cp0"}, q_re[0], expc);
        check({tag, "_body0"}, q_re[16], v.body0);
        check({tag, "_body63"}, q_re[79], v.body63);
        check({tag, "_burst_end"}, int'(q_eob[79]), int'(v.burst));
        cmp_seq(tag, 80);
    endtask

    initial begin
        vec_t vecs[4];
        vecs[0] = '{0,    0,     1'b1, 1'b0, 48,    24,    0,    63,    1'b1};
        vecs[1] = '{100,  0,     1'b0, 1'b1, 148,   74,    100,  163,   1'b0};
        vecs[2] = '{-10,  5,     1'b1, 1'b0, 38,    69,    -10,  53,    1'b1};
        vecs[3] = '{2000, -2000, 1'b1, 1'b0, -2048, -1024, 2000, -2033, 1'b1};

        reset = 1'b0; valid_in = 1'b0; last_symbol_in = 1'b0;
        data_in_real = '0; data_in_imag = '0; index_in = '0;
        drive_n = 0; first_low = -1; first_ovf = -1;
        repeat (3) step();
        check("reset_state", state_vec(), 1 << 28);
        reset = 1'b1;
        repeat (2) step();
        check("idle_after_reset", state_vec(), 1 << 28);

        for (int v = 0; v < 4; v++) begin
            run_vec(vecs[v], $sformatf("vec%0d", v));
        end

        // Sustained rate: 64 samples then 16 idle cycles, three symbols.
        clear_q();
        drive_n = 0; first_low = -1; first_ovf = -1;
        for (int s = 0; s < 3; s++) begin
            fill_sym(300 + 700 * s, -11 * s);
            model_push(s == 2);
            write_sym(s == 2, 1'b0);
            repeat (16) step();
        end
        wait_q(240, 300);
        repeat (5) step();
        check("rate_count", q_re.size(), 240);
        pad_q(240);
        check("rate_contig", q_cyc[239] - q_cyc[0], 239);
        check("rate_ready_low", first_low, -1);
        check("rate_overflow", int'(overflow), 0);
        cmp_seq("rate", 240);

        // Input at one sample per cycle: third symbol collides with the still-full first bank.
        clear_q();
        drive_n = 0; first_low = -1; first_ovf = -1;
        for (int s = 0; s < 3; s++) begin
            fill_sym(7 + 400 * s, 33 - 50 * s);
            if (s < 2) model_push(1'b0);
            write_sym(1'b0, 1'b0);
        end
        check("ovf_first_ready_low", first_low, 128);
        check("ovf_first_seen", first_ovf, 129);
        wait_q(200, 400);
        pad_q(200);
        check("ovf_contig", q_cyc[159] - q_cyc[0], 159);
        cmp_seq("ovf", 160);
        check("ovf_sticky", int'(overflow), 1);
        check("ovf_mid_body_valid", int'(valid_out), 1);

        // Reset asserted while the third symbol is in its body.
        reset = 1'b0;
        step();
        check("rst_mid_state", state_vec(), 1 << 28);
        reset = 1'b1;
`ifdef WIFI_CP_WINDOW_EN
        m_prev_re = 0;
        m_prev_im = 0;
`endif
        repeat (2) step();
        check("rst_release_state", state_vec(), 1 << 28);
        run_vec(vecs[0], "post_rst");
        check("idle_outputs_zero", idle_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
